// File: rtl/uart_arbiter.sv
// uart_arbiter
//   Arbitrates two requester ports onto a single UART engine. Each port may
//   ask for a transmit or a receive transfer. The arbiter issues a one-cycle
//   command pulse to the engine, waits for the matching completion pulse,
//   then acks the owning port.
//
// Ports
//   clk, rstn            : clock, synchronous active-low reset
//   req_tx0/req_rx0      : port-0 transmit / receive request (level)
//   wdata0, lock0        : port-0 transmit byte, ownership-retain request
//   ack0, rdata0         : port-0 completion pulse, received byte
//   req_tx1 .. rdata1    : same set for port 1
//   u_ready              : engine idle and able to accept a command
//   t_valid, r_valid     : transmit / receive command pulses to the engine
//   t_data               : byte to transmit, held until the transfer completes
//   r_data               : byte from the engine, valid with rx_done
//   tx_done, rx_done     : engine completion pulses
//   busy, owner          : transfer outstanding, port of current/last grant
module uart_arbiter (
  input  logic       clk,
  input  logic       rstn,
  input  logic       req_tx0,
  input  logic       req_rx0,
  input  logic [7:0] wdata0,
  input  logic       lock0,
  output logic       ack0,
  output logic [7:0] rdata0,
  input  logic       req_tx1,
  input  logic       req_rx1,
  input  logic [7:0] wdata1,
  input  logic       lock1,
  output logic       ack1,
  output logic [7:0] rdata1,
  input  logic       u_ready,
  output logic       t_valid,
  output logic       r_valid,
  output logic [7:0] t_data,
  input  logic [7:0] r_data,
  input  logic       tx_done,
  input  logic       rx_done,
  output logic       busy,
  output logic       owner
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT
  } state_t;

  state_t     state_q;
  logic       op_tx_q;
  logic       last_grant_q;
  logic       lock_hold_q;
  logic       owner_q;
  logic       busy_q;
  logic       t_valid_q;
  logic       r_valid_q;
  logic [7:0] t_data_q;
  logic       ack0_q;
  logic       ack1_q;
  logic [7:0] rdata0_q;
  logic [7:0] rdata1_q;

  logic       want0, want1;
  logic       elig0, elig1;
  logic       lock_req, other_req;
  logic       cand_ok;
  logic       grant_ok;
  logic       grant_port;
  logic       grant_tx;
  logic [7:0] grant_wdata;
  logic       done_match;
  logic       owner_lock;

  always_comb begin
    want0     = req_tx0 | req_rx0;
    want1     = req_tx1 | req_rx1;
    // A port being acked this cycle still shows its old request level.
    elig0     = want0 & ~ack0_q;
    elig1     = want1 & ~ack1_q;
    // The locked port is always the last one granted.
    lock_req  = last_grant_q ? want1 : want0;
    other_req = last_grant_q ? want0 : want1;
    cand_ok    = 1'b0;
    grant_port = 1'b0;
    if (lock_hold_q && lock_req) begin
      // Reserve the engine for the locked port, even through its ack cycle.
      grant_port = last_grant_q;
      cand_ok    = last_grant_q ? elig1 : elig0;
    end else if (elig0 && elig1) begin
      grant_port = ~last_grant_q;
      cand_ok    = 1'b1;
    end else begin
      grant_port = elig1;
      cand_ok    = elig0 | elig1;
    end
    grant_ok    = u_ready & cand_ok;
    grant_tx    = grant_port ? req_tx1 : req_tx0;
    grant_wdata = grant_port ? wdata1 : wdata0;
    done_match  = op_tx_q ? tx_done : rx_done;
    owner_lock  = owner_q ? lock1 : lock0;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      op_tx_q      <= 1'b0;
      last_grant_q <= 1'b1;
      lock_hold_q  <= 1'b0;
      owner_q      <= 1'b0;
      busy_q       <= 1'b0;
      t_valid_q    <= 1'b0;
      r_valid_q    <= 1'b0;
      t_data_q     <= '0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (grant_ok) begin
            owner_q     <= grant_port;
            op_tx_q     <= grant_tx;
            if (grant_tx) begin
              t_data_q <= grant_wdata;
            end
            t_valid_q   <= grant_tx;
            r_valid_q   <= ~grant_tx;
            busy_q      <= 1'b1;
            lock_hold_q <= 1'b0;
            state_q     <= S_ISSUE;
          end else if (lock_hold_q && !lock_req && other_req) begin
            lock_hold_q <= 1'b0;
          end
        end
        S_ISSUE: begin
          t_valid_q <= 1'b0;
          r_valid_q <= 1'b0;
          state_q   <= S_WAIT;
        end
        S_WAIT: begin
          if (done_match) begin
            if (owner_q) begin
              ack1_q <= 1'b1;
              if (!op_tx_q) begin
                rdata1_q <= r_data;
              end
            end else begin
              ack0_q <= 1'b1;
              if (!op_tx_q) begin
                rdata0_q <= r_data;
              end
            end
            busy_q       <= 1'b0;
            last_grant_q <= owner_q;
            lock_hold_q  <= owner_lock;
            state_q      <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ack0    = ack0_q;
  assign ack1    = ack1_q;
  assign rdata0  = rdata0_q;
  assign rdata1  = rdata1_q;
  assign t_valid = t_valid_q;
  assign r_valid = r_valid_q;
  assign t_data  = t_data_q;
  assign busy    = busy_q;
  assign owner   = owner_q;

endmodule

// File: tb/tb_uart_arbiter.sv
// tb_uart_arbiter
//   Drives uart_arbiter with directed scenarios followed by randomized
//   requesters and a randomized UART engine, comparing every output on
//   every cycle against a transfer-level reference model.
module tb_uart_arbiter;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstn;
  logic       req_tx0, req_rx0, lock0, req_tx1, req_rx1, lock1;
  logic [7:0] wdata0, wdata1, r_data;
  logic       u_ready, tx_done, rx_done;
  logic       ack0, ack1, t_valid, r_valid, busy, owner;
  logic [7:0] rdata0, rdata1, t_data;

  uart_arbiter dut (
    .clk     (clk),
    .rstn    (rstn),
    .req_tx0 (req_tx0),
    .req_rx0 (req_rx0),
    .wdata0  (wdata0),
    .lock0   (lock0),
    .ack0    (ack0),
    .rdata0  (rdata0),
    .req_tx1 (req_tx1),
    .req_rx1 (req_rx1),
    .wdata1  (wdata1),
    .lock1   (lock1),
    .ack1    (ack1),
    .rdata1  (rdata1),
    .u_ready (u_ready),
    .t_valid (t_valid),
    .r_valid (r_valid),
    .t_data  (t_data),
    .r_data  (r_data),
    .tx_done (tx_done),
    .rx_done (rx_done),
    .busy    (busy),
    .owner   (owner)
  );

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: one outstanding transfer described by who/what, plus
  // a flag for the single command-pulse cycle that follows a grant.
  bit         m_busy, m_issue, m_tx, m_owner, m_last, m_lk;
  bit         m_ack [2];
  logic [7:0] m_tdata;
  logic [7:0] m_rdata [2];
  int         grants[$];
  int         dut_grants[$];

  // Stimulus controls
  bit rand_mode, auto_drop, eng_auto, eng_strays, eng_fix, eng_tx;
  int eng_cnt, eng_lat_max;
  logic [7:0] eng_val;

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic model_step();
    bit want [2];
    bit can  [2];
    bit txr  [2];
    bit lk   [2];
    logic [7:0] wd [2];
    bit prev_ack [2];
    int win;
    want[0] = req_tx0 | req_rx0;  want[1] = req_tx1 | req_rx1;
    txr[0]  = req_tx0;            txr[1]  = req_tx1;
    wd[0]   = wdata0;             wd[1]   = wdata1;
    lk[0]   = lock0;              lk[1]   = lock1;
    if (!rstn) begin
      m_busy = 0; m_issue = 0; m_tx = 0; m_owner = 0; m_last = 1; m_lk = 0;
      m_ack = '{0, 0}; m_tdata = 8'h00; m_rdata = '{8'h00, 8'h00};
      return;
    end
    prev_ack = m_ack;
    m_ack = '{0, 0};
    if (!m_busy) begin
      for (int p = 0; p < 2; p++) can[p] = want[p] && !prev_ack[p];
      win = -1;
      if (m_lk && want[m_last]) win = can[m_last] ? int'(m_last) : -1;
      else if (can[0] && can[1]) win = 1 - int'(m_last);
      else if (can[0]) win = 0;
      else if (can[1]) win = 1;
      if (win >= 0 && u_ready) begin
        m_owner = win[0];
        m_tx    = txr[win];
        if (m_tx) m_tdata = wd[win];
        m_busy  = 1;
        m_issue = 1;
        m_lk    = 0;
        grants.push_back(win);
      end else if (m_lk && !want[m_last] && want[1 - int'(m_last)]) begin
        m_lk = 0;
      end
    end else if (m_issue) begin
      m_issue = 0;
    end else if (m_tx ? tx_done : rx_done) begin
      m_ack[m_owner] = 1;
      if (!m_tx) m_rdata[m_owner] = r_data;
      m_busy = 0;
      m_last = m_owner;
      m_lk   = lk[m_owner];
    end
  endtask

  task automatic check_outputs();
    chk("t_valid", t_valid, m_issue && m_tx);
    chk("r_valid", r_valid, m_issue && !m_tx);
    chk("t_data",  t_data,  m_tdata);
    chk("ack0",    ack0,    m_ack[0]);
    chk("ack1",    ack1,    m_ack[1]);
    chk("rdata0",  rdata0,  m_rdata[0]);
    chk("rdata1",  rdata1,  m_rdata[1]);
    chk("busy",    busy,    m_busy);
    chk("owner",   owner,   m_owner);
  endtask

  task automatic rand_req(input logic acked, inout logic tx, inout logic rx,
                          inout logic [7:0] wd, inout logic lk);
    int k;
    if (acked) return;
    if (!tx && !rx) begin
      if ($urandom_range(0, 2) == 0) begin
        k  = $urandom_range(1, 3);
        tx = k[0];
        rx = k[1];
        wd = 8'($urandom);
        lk = ($urandom_range(0, 2) == 0);
      end
    end else if ($urandom_range(0, 29) == 0) begin
      tx = 0;
      rx = 0;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
    if (t_valid || r_valid) dut_grants.push_back(int'(owner));
    tx_done = 0;
    rx_done = 0;
    if (rand_mode) begin
      rstn    = ($urandom_range(0, 299) != 0);
      u_ready = ($urandom_range(0, 9) != 0);
    end
    if (eng_auto) begin
      if (eng_cnt > 0) begin
        eng_cnt--;
        if (eng_cnt == 0) begin
          if (eng_tx) tx_done = 1;
          else begin
            rx_done = 1;
            r_data  = eng_fix ? eng_val : 8'($urandom);
          end
        end
      end
      if (t_valid || r_valid) begin
        eng_cnt = $urandom_range(1, eng_lat_max);
        eng_tx  = t_valid;
      end
      if (eng_strays && $urandom_range(0, 14) == 0) begin
        if ($urandom_range(0, 1) == 1) tx_done = 1;
        else begin
          rx_done = 1;
          r_data  = 8'($urandom);
        end
      end
      if (!rstn) eng_cnt = 0;
    end
    if (auto_drop) begin
      if (ack0) begin req_tx0 = 0; req_rx0 = 0; end
      if (ack1) begin req_tx1 = 0; req_rx1 = 0; end
    end
    if (rand_mode) begin
      rand_req(ack0, req_tx0, req_rx0, wdata0, lock0);
      rand_req(ack1, req_tx1, req_rx1, wdata1, lock1);
    end
  endtask

  task automatic wait_ack(input int p, input string name);
    bit seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      cycle();
      if ((p == 0 ? ack0 : ack1) === 1'b1) seen = 1;
    end
    n_total++;
    if (!seen) begin
      n_bad++;
      $display("FAIL %s got=no-ack exp=ack", name);
    end
  endtask

  task automatic do_reset();
    rand_mode = 0; auto_drop = 1; eng_auto = 1; eng_strays = 0; eng_fix = 0;
    eng_cnt = 0; eng_lat_max = 4; eng_val = 8'h00;
    req_tx0 = 0; req_rx0 = 0; lock0 = 0; wdata0 = 8'h00;
    req_tx1 = 0; req_rx1 = 0; lock1 = 0; wdata1 = 8'h00;
    u_ready = 1; tx_done = 0; rx_done = 0; r_data = 8'h00;
    rstn = 0;
    cycle();
    cycle();
    rstn = 1;
  endtask

  task automatic chk_seq(input string name, input int q[$], input int e0, input int e1,
                         input int e2, input int e3);
    int e [4];
    e = '{e0, e1, e2, e3};
    for (int i = 0; i < 4; i++)
      chk(name, (i < q.size()) ? 8'(q[i]) : 8'hFF, 8'(e[i]));
  endtask

  initial begin
    do_reset();
    chk("rst_busy", busy, 1'b0);
    chk("rst_owner", owner, 1'b0);
    chk("rst_tdata", t_data, 8'h00);

    // Port-0 transmit of 0x41
    req_tx0 = 1; wdata0 = 8'h41;
    cycle();
    chk("s35_tvalid", t_valid, 1'b1);
    chk("s35_tdata", t_data, 8'h41);
    chk("s35_owner", owner, 1'b0);
    cycle();
    chk("s35_tvalid_off", t_valid, 1'b0);
    chk("s35_tdata_hold", t_data, 8'h41);
    wait_ack(0, "s35_ack");
    chk("s35_tdata_done", t_data, 8'h41);
    chk("s35_rdata0", rdata0, 8'h00);
    cycle();
    chk("s35_ack_one", ack0, 1'b0);

    // Port-1 receive of 0x5A
    do_reset();
    eng_fix = 1; eng_val = 8'h5A;
    req_rx1 = 1;
    wait_ack(1, "s36_ack");
    chk("s36_rdata1", rdata1, 8'h5A);
    chk("s36_owner", owner, 1'b1);
    chk("s36_rdata0", rdata0, 8'h00);

    // Fair alternation with both ports transmitting continuously
    do_reset();
    auto_drop = 0;
    req_tx0 = 1; req_tx1 = 1; wdata0 = 8'h11; wdata1 = 8'h22;
    grants.delete(); dut_grants.delete();
    for (int i = 0; i < 200 && dut_grants.size() < 4; i++) cycle();
    chk_seq("s37_dut", dut_grants, 0, 1, 0, 1);
    chk_seq("s37_model", grants, 0, 1, 0, 1);

    // Lock keeps port 0 for three transfers, then releases to port 1
    do_reset();
    auto_drop = 0;
    req_tx0 = 1; req_tx1 = 1; lock0 = 1; wdata0 = 8'h33; wdata1 = 8'h44;
    grants.delete(); dut_grants.delete();
    for (int i = 0; i < 200 && dut_grants.size() < 3; i++) cycle();
    lock0 = 0;
    for (int i = 0; i < 200 && dut_grants.size() < 4; i++) cycle();
    chk_seq("s38_dut", dut_grants, 0, 0, 0, 1);
    chk_seq("s38_model", grants, 0, 0, 0, 1);

    // Stray completions and a stalled engine
    do_reset();
    eng_auto = 0;
    req_tx0 = 1; wdata0 = 8'h77;
    cycle();
    cycle();
    rx_done = 1; r_data = 8'hEE;
    cycle();
    chk("s39_stray_ack", ack0, 1'b0);
    chk("s39_stray_busy", busy, 1'b1);
    cycle();
    chk("s39_still_busy", busy, 1'b1);
    tx_done = 1;
    cycle();
    chk("s39_ack", ack0, 1'b1);
    chk("s39_rdata0", rdata0, 8'h00);
    cycle();
    tx_done = 1;
    cycle();
    chk("s39_idle_ack", ack0, 1'b0);
    chk("s39_idle_busy", busy, 1'b0);
    u_ready = 0; req_tx1 = 1; wdata1 = 8'h99;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("s39_noready", t_valid, 1'b0);
    end
    u_ready = 1;
    cycle();
    chk("s39_grant", t_valid, 1'b1);
    chk("s39_owner", owner, 1'b1);
    cycle();
    tx_done = 1;
    cycle();
    chk("s39_ack1", ack1, 1'b1);

    // Reset while port 1 waits; port 0 must win first afterwards
    do_reset();
    eng_auto = 0;
    req_tx0 = 1; wdata0 = 8'h01;
    cycle();
    cycle();
    tx_done = 1;
    cycle();
    chk("s40_ack0", ack0, 1'b1);
    req_tx1 = 1; wdata1 = 8'h02;
    cycle();
    cycle();
    chk("s40_wait_owner", owner, 1'b1);
    req_tx0 = 1;
    rstn = 0;
    cycle();
    chk("s40_rst_busy", busy, 1'b0);
    chk("s40_rst_owner", owner, 1'b0);
    chk("s40_rst_tdata", t_data, 8'h00);
    chk("s40_rst_ack1", ack1, 1'b0);
    rstn = 1;
    cycle();
    chk("s40_first_owner", owner, 1'b0);
    chk("s40_first_tvalid", t_valid, 1'b1);
    chk("s40_first_tdata", t_data, 8'h01);

    // Randomized traffic with strays, stalls, drops and resets
    do_reset();
    rand_mode = 1; eng_strays = 1; eng_lat_max = 5;
    for (int i = 0; i < 4000; i++) cycle();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
